// File: rtl/mor1kx_pcu_if.sv
// SPR bus port bundle for the performance counter unit.
// The master issues accesses; the PCU answers as the slave.
interface mor1kx_pcu_if;
  logic        spr_access_i;
  logic        spr_we_i;
  logic [15:0] spr_addr_i;
  logic [31:0] spr_dat_i;
  logic        spr_bus_ack_o;
  logic [31:0] spr_dat_o;

  modport master (
    output spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
    input  spr_bus_ack_o, spr_dat_o
  );

  modport slave (
    input  spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
    output spr_bus_ack_o, spr_dat_o
  );
endinterface

// File: rtl/mor1kx_pcu.sv
// Performance counter unit (SPR group 7): per-counter PCCR/PCMR lanes
// behind a one-cycle-latency SPR slave.
module mor1kx_pcu_cnt #(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sm,
  input  logic [10:0]   ev,
  input  logic          cnt_we,
  input  logic          mr_we,
  input  logic [31:0]   wdat,
  output logic [W-1:0]  cnt,
  output logic [14:2]   mr,
  output logic          ovf
);
  logic en, hit, inc;
  logic unused_wdat;

  assign en  = (mr[2] & sm) | (mr[3] & ~sm);
  assign hit = |(ev & mr[14:4]);
  assign inc = en & hit;
  assign unused_wdat = ^{wdat[31:15], wdat[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      mr  <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (mr_we) mr <= wdat[14:2];
      // A software write to the counter overrides a same-cycle increment.
      if (cnt_we) cnt <= wdat[W-1:0];
      else if (inc) begin
        cnt <= cnt + 1'b1;
        ovf <= &cnt;
      end
    end
  end
endmodule

module mor1kx_pcu #(
  parameter int OPTION_PERFCOUNTERS_NUM = 1,
  parameter int OPTION_PCCR_WIDTH       = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  mor1kx_pcu_if.slave                        spr,
  input  logic                               spr_sr_sm_i,
  input  logic [10:0]                        event_i,
  output logic [OPTION_PERFCOUNTERS_NUM-1:0] pcu_ovf_o,
  output logic [31:0]                        spr_pccfgr
);
  localparam int NUM = OPTION_PERFCOUNTERS_NUM;
  localparam int W   = OPTION_PCCR_WIDTH;

  typedef enum logic {IDLE, ACK} state_t;
  state_t state_q, state_d;

  logic [NUM-1:0][W-1:0]  cnt;
  logic [NUM-1:0][12:0]   mr;
  logic [NUM-1:0]         cnt_we, mr_we;
  logic                   grp7, req, wr;
  logic [7:0]             bank;
  logic [2:0]             sel;
  logic [31:0]            rd_mux, rdata_q;

  assign grp7 = spr.spr_addr_i[15:11] == 5'd7;
  assign bank = spr.spr_addr_i[10:3];
  assign sel  = spr.spr_addr_i[2:0];
  assign req  = spr.spr_access_i & grp7;
  assign wr   = (state_q == IDLE) & req & spr.spr_we_i;

  assign spr_pccfgr = 32'(NUM);

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    assign cnt_we[i] = wr & (bank == 8'd0) & (sel == 3'(i));
    assign mr_we[i]  = wr & (bank == 8'd1) & (sel == 3'(i));
    mor1kx_pcu_cnt #(.W(W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .sm     (spr_sr_sm_i),
      .ev     (event_i),
      .cnt_we (cnt_we[i]),
      .mr_we  (mr_we[i]),
      .wdat   (spr.spr_dat_i),
      .cnt    (cnt[i]),
      .mr     (mr[i]),
      .ovf    (pcu_ovf_o[i])
    );
  end

  // Unimplemented and reserved indices fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM; i++) begin
      if (sel == 3'(i)) begin
        if (bank == 8'd0) rd_mux = 32'(cnt[i]);
        else if (bank == 8'd1) rd_mux = {17'b0, mr[i], 2'b01};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) rdata_q <= rd_mux;
    end
  end

  assign spr.spr_bus_ack_o = state_q == ACK;
  assign spr.spr_dat_o     = (state_q == ACK) ? rdata_q : 32'h0;
endmodule

// File: tb/tb_mor1kx_pcu.sv
// Bench for mor1kx_pcu: directed SPR/counting scenarios on a 2x32-bit and a
// 1x8-bit instance, then randomized counting against an arithmetic model.
module tb_mor1kx_pcu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sm;
  logic [10:0] ev_a, ev_b;
  logic [1:0]  ovf_a;
  logic [0:0]  ovf_b;
  logic [31:0] cfg_a, cfg_b;

  mor1kx_pcu_if ifa ();
  mor1kx_pcu_if ifb ();

  mor1kx_pcu #(.OPTION_PERFCOUNTERS_NUM(2), .OPTION_PCCR_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .spr(ifa), .spr_sr_sm_i(sm), .event_i(ev_a),
    .pcu_ovf_o(ovf_a), .spr_pccfgr(cfg_a));
  mor1kx_pcu #(.OPTION_PERFCOUNTERS_NUM(1), .OPTION_PCCR_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .spr(ifb), .spr_sr_sm_i(sm), .event_i(ev_b),
    .pcu_ovf_o(ovf_b), .spr_pccfgr(cfg_b));

  int checks = 0;
  int errors = 0;

  // Overflow pulse monitor on the 8-bit instance: pulses and over-long pulses.
  int   ovf_b_cnt = 0;
  int   ovf_b_wide = 0;
  logic ovf_b_prev = 1'b0;
  always @(negedge clk) begin
    if (ovf_b[0]) begin
      ovf_b_cnt++;
      if (ovf_b_prev) ovf_b_wide++;
    end
    ovf_b_prev = ovf_b[0];
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic acc, input logic we,
                       input logic [15:0] a, input logic [31:0] d);
    if (b) begin
      ifb.spr_access_i = acc; ifb.spr_we_i = we; ifb.spr_addr_i = a; ifb.spr_dat_i = d;
    end else begin
      ifa.spr_access_i = acc; ifa.spr_we_i = we; ifa.spr_addr_i = a; ifa.spr_dat_i = d;
    end
  endtask

  // One SPR access; lat = cycles until ack (0 = never acked within 4 cycles).
  // Events are held only up to the first edge of the access.
  task automatic spr(input bit b, input logic we, input logic [15:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output int lat);
    lat = 0;
    rd  = '0;
    drive(b, 1'b1, we, a, d);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      ev_a = '0; ev_b = '0;
      if (b ? ifb.spr_bus_ack_o : ifa.spr_bus_ack_o) begin
        lat = n;
        rd  = b ? ifb.spr_dat_o : ifa.spr_dat_o;
        break;
      end
    end
    drive(b, 1'b0, 1'b0, 16'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit b, input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    spr(b, 1'b1, a, d, rd, lat);
    chk($sformatf("wr_lat_%0d_%h", b, a), 32'(lat), 32'd1);
  endtask

  task automatic rd_chk(input bit b, input logic [15:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    int lat;
    spr(b, 1'b0, a, 32'h0, rd, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk(tag, rd, exp);
  endtask

  localparam logic [15:0] PCCR = 16'h3800;
  localparam logic [15:0] PCMR = 16'h3808;

  initial begin
    logic [31:0]     rd;
    int              lat, base, wbase, exp_ovf;
    logic [31:0]     mr_m [3];
    longint unsigned cnt_m [3];
    longint unsigned mask;
    logic [31:0]     v;

    rst = 1'b1; sm = 1'b0; ev_a = '0; ev_b = '0;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ifa.spr_bus_ack_o}, 32'd0);
    chk("rst_dat", ifa.spr_dat_o, 32'd0);
    chk("rst_ovf", {29'b0, ovf_b, ovf_a}, 32'd0);
    chk("pccfgr_a", cfg_a, 32'd2);
    chk("pccfgr_b", cfg_b, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset contents and the unimplemented bank entries.
    rd_chk(0, PCMR, 32'h1, "rst_pcmr0");
    rd_chk(0, PCCR, 32'h0, "rst_pccr0");
    rd_chk(0, PCMR + 16'd1, 32'h1, "rst_pcmr1");
    rd_chk(0, PCMR + 16'd2, 32'h0, "pcmr_num_a");
    rd_chk(1, PCMR + 16'd1, 32'h0, "pcmr_num_b");

    // Supervisor-only LA counting.
    wr(0, PCMR, 32'h14);
    sm = 1'b1; ev_a = 11'h1;
    repeat (10) @(posedge clk);
    #1; ev_a = '0;
    rd_chk(0, PCCR, 32'd10, "cism_count");
    sm = 1'b0; ev_a = 11'h1;
    repeat (10) @(posedge clk);
    #1; ev_a = '0;
    rd_chk(0, PCCR, 32'd10, "user_gated");

    // Two events in a cycle give one increment.
    wr(0, PCMR, 32'h34);
    wr(0, PCCR, 32'h0);
    sm = 1'b1; ev_a = 11'h3;
    repeat (5) @(posedge clk);
    #1; ev_a = '0;
    rd_chk(0, PCCR, 32'd5, "multi_event");

    // Write collides with a counted event: the written value sticks.
    ev_a = 11'h1;
    wr(0, PCCR, 32'h100);
    rd_chk(0, PCCR, 32'h100, "write_wins");
    chk("write_wins_noovf", {30'b0, ovf_a}, 32'd0);

    wr(0, PCMR, 32'hFFFF_FFFF);
    rd_chk(0, PCMR, 32'h7FFD, "pcmr_mask");

    rd_chk(0, PCCR + 16'd20, 32'h0, "reserved_rd");
    wr(0, PCCR + 16'd20, 32'hFFFF_FFFF);
    spr(0, 1'b1, 16'h3000, 32'h5, rd, lat);
    chk("grp6_wr_noack", 32'(lat), 32'd0);
    spr(0, 1'b0, 16'h3008, 32'h0, rd, lat);
    chk("grp6_rd_noack", 32'(lat), 32'd0);
    rd_chk(0, PCCR, 32'h100, "ignored_writes");

    // 8-bit wrap: 0xFE + 2 counted events.
    wr(1, PCMR, 32'h14);
    wr(1, PCCR, 32'hFE);
    base = ovf_b_cnt; wbase = ovf_b_wide;
    sm = 1'b1; ev_b = 11'h1;
    @(posedge clk); #1;
    chk("wrap_pre", {31'b0, ovf_b}, 32'd0);
    @(posedge clk); #1;
    ev_b = '0;
    chk("wrap_pulse", {31'b0, ovf_b}, 32'd1);
    @(posedge clk); #1;
    chk("wrap_pulse_end", {31'b0, ovf_b}, 32'd0);
    rd_chk(1, PCCR, 32'h0, "wrap_value");
    chk("wrap_count", 32'(ovf_b_cnt - base), 32'd1);
    chk("wrap_width", 32'(ovf_b_wide - wbase), 32'd0);

    // Reset arriving together with a write access.
    drive(0, 1'b1, 1'b1, PCCR, 32'h55);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack0", {31'b0, ifa.spr_bus_ack_o}, 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_ack1", {31'b0, ifa.spr_bus_ack_o}, 32'd0);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(posedge clk); #1;
    rd_chk(0, PCCR, 32'h0, "rst_mid_pccr");
    rd_chk(0, PCMR, 32'h1, "rst_mid_pcmr");

    // Randomized counting: lanes 0,1 = 32-bit instance, lane 2 = 8-bit instance.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 3; c++) begin
        mask = (c == 2) ? 64'hFF : 64'hFFFF_FFFF;
        v = $urandom;
        wr(c == 2, PCMR + 16'(c % 2), v);
        mr_m[c] = v & 32'h7FFC;
        v = (c == 2) ? 32'($urandom_range(240, 255)) : $urandom;
        wr(c == 2, PCCR + 16'(c % 2), v);
        cnt_m[c] = longint'(v) & mask;
      end
      base = ovf_b_cnt;
      exp_ovf = 0;
      repeat (40) begin
        sm   = 1'($urandom_range(0, 1));
        ev_a = 11'($urandom);
        ev_b = 11'($urandom);
        for (int c = 0; c < 3; c++) begin
          logic [10:0] evs;
          bit en;
          evs  = (c == 2) ? ev_b : ev_a;
          mask = (c == 2) ? 64'hFF : 64'hFFFF_FFFF;
          en   = sm ? mr_m[c][2] : mr_m[c][3];
          if (en && ((evs & mr_m[c][14:4]) != 0)) begin
            cnt_m[c] = (cnt_m[c] + 1) & mask;
            if (cnt_m[c] == 0 && c == 2) exp_ovf++;
          end
        end
        @(posedge clk); #1;
      end
      ev_a = '0; ev_b = '0;
      for (int c = 0; c < 3; c++) begin
        rd_chk(c == 2, PCCR + 16'(c % 2), 32'(cnt_m[c]), $sformatf("rnd%0d_pccr%0d", r, c));
        rd_chk(c == 2, PCMR + 16'(c % 2), mr_m[c] | 32'h1, $sformatf("rnd%0d_pcmr%0d", r, c));
      end
      chk($sformatf("rnd%0d_ovf", r), 32'(ovf_b_cnt - base), 32'(exp_ovf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
